alu_issue: RTL and testbench

- Producer side of the ALU operand interface. Accepts decoded ops from the decode stage over a valid/ready handshake.
- Resolves operands by forwarding from EX and from writeback, selects the immediate, and registers src1/src2/funct3/is_branch for the combinational ALU.
- A one-entry skid buffer absorbs downstream backpressure without a combinational in_ready path.

---
 rtl/core_pkg.sv | 38 +++
 rtl/alu_operand_fwd.sv | 31 +++
 rtl/alu_issue.sv | 179 +++++++++++++++++
 tb/tb_alu_issue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared issue-stage types: datapath widths, ALU/branch function codes and the decoded-op record.
package core_pkg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_MIN = 3'b001;
    localparam logic [2:0] F3_SLL = 3'b010;
    localparam logic [2:0] F3_MAX = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_B010 = 3'b010;
    localparam logic [2:0] BR_B011 = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [2:0]      funct3;
        logic            is_branch;
        logic            use_imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rd;
    } issue_op_t;
endpackage

// File: rtl/alu_operand_fwd.sv
// Resolves one source operand: x0 reads zero, then EX result, then writeback data, then the raw value.
module alu_operand_fwd #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic [XLEN-1:0] i_raw,
    input  logic            i_ex_en,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic [XLEN-1:0] i_ex_data,
    input  logic            i_wb_en,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_val,
    output logic            o_fwd
);
    // A nonzero rs guarantees the matched EX/WB destination is nonzero too
    always_comb begin
        o_val = i_raw;
        o_fwd = 1'b0;
        if (i_rs == '0) begin
            o_val = '0;
        end else if (i_ex_en && (i_ex_rd == i_rs)) begin
            o_val = i_ex_data;
            o_fwd = 1'b1;
        end else if (i_wb_en && (i_wb_rd == i_rs)) begin
            o_val = i_wb_data;
            o_fwd = 1'b1;
        end
    end
endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: one-entry skid buffer with EX/WB operand forwarding and held-operand refresh.
// Define ALU_ISSUE_STATS_EN to add the stat_issued/stat_stall/stat_fwd counters.
module alu_issue #(
    parameter int XLEN = core_pkg::XLEN,
    parameter int RA_W = core_pkg::RA_W
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_is_branch,
    input  logic            in_use_imm,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [2:0]      out_funct3,
    output logic            out_is_branch,
    output logic [RA_W-1:0] out_rd
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_stall,
    output logic [31:0]     stat_fwd
`endif
);
    import core_pkg::*;

    issue_state_t    r_state, w_state_nxt;
    issue_op_t       r_skid, w_in_op, w_ld_op, w_sk_op;
    logic [XLEN-1:0] r_src1, r_src2;
    logic [2:0]      r_funct3;
    logic            r_is_branch, r_src2_reg;
    logic [RA_W-1:0] r_rd, r_rs1, r_rs2;
    logic            w_fire, w_accept, w_load_out, w_load_skid, w_from_skid;
    logic [XLEN-1:0] w_ld_src1, w_ld_src2, w_sk_rs1, w_sk_rs2;
    logic            w_ld_fwd1, w_ld_fwd2, w_sk_fwd1, w_sk_fwd2;
    logic            w_unused_fwd;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_fire    = out_valid && out_ready;
    assign w_accept  = in_valid && in_ready;

    assign w_in_op = '{funct3: in_funct3, is_branch: in_is_branch, use_imm: in_use_imm,
                       rs1: in_rs1, rs2: in_rs2, rs1_val: in_rs1_val, rs2_val: in_rs2_val,
                       imm: in_imm, rd: in_rd};
    assign w_ld_op = w_from_skid ? r_skid : w_in_op;
    // Skid refresh follows the stored entry while full, otherwise captures the incoming op
    assign w_sk_op = (r_state == ST_FULL) ? r_skid : w_in_op;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: if (w_accept) begin
                w_state_nxt = ST_HOLD;
                w_load_out  = 1'b1;
            end
            ST_HOLD: begin
                if (w_accept && w_fire) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: if (w_fire) begin
                w_state_nxt = ST_HOLD;
                w_load_out  = 1'b1;
                w_from_skid = 1'b1;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    alu_operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_ld1 (
        .i_rs(w_ld_op.rs1), .i_raw(w_ld_op.rs1_val), .i_ex_en(w_fire), .i_ex_rd(r_rd),
        .i_ex_data(alu_result), .i_wb_en(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_ld_src1), .o_fwd(w_ld_fwd1));
    alu_operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_ld2 (
        .i_rs(w_ld_op.rs2), .i_raw(w_ld_op.rs2_val), .i_ex_en(w_fire), .i_ex_rd(r_rd),
        .i_ex_data(alu_result), .i_wb_en(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_ld_src2), .o_fwd(w_ld_fwd2));
    alu_operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_sk1 (
        .i_rs(w_sk_op.rs1), .i_raw(w_sk_op.rs1_val), .i_ex_en(1'b0), .i_ex_rd('0),
        .i_ex_data('0), .i_wb_en(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_sk_rs1), .o_fwd(w_sk_fwd1));
    alu_operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_sk2 (
        .i_rs(w_sk_op.rs2), .i_raw(w_sk_op.rs2_val), .i_ex_en(1'b0), .i_ex_rd('0),
        .i_ex_data('0), .i_wb_en(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_sk_rs2), .o_fwd(w_sk_fwd2));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_skid <= '0;
        end else if (w_load_skid || (r_state == ST_FULL)) begin
            r_skid         <= w_sk_op;
            r_skid.rs1_val <= w_sk_rs1;
            r_skid.rs2_val <= w_sk_rs2;
        end
    end

    // Output register: load on move, otherwise let writeback refresh a held register operand
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_src1      <= '0;
            r_src2      <= '0;
            r_funct3    <= '0;
            r_is_branch <= 1'b0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_src2_reg  <= 1'b0;
        end else if (w_load_out) begin
            r_src1      <= w_ld_src1;
            r_src2      <= w_ld_op.use_imm ? w_ld_op.imm : w_ld_src2;
            r_funct3    <= w_ld_op.funct3;
            r_is_branch <= w_ld_op.is_branch;
            r_rd        <= w_ld_op.is_branch ? '0 : w_ld_op.rd;
            r_rs1       <= w_ld_op.rs1;
            r_rs2       <= w_ld_op.rs2;
            r_src2_reg  <= !w_ld_op.use_imm;
        end else if (out_valid && !w_fire && wb_valid) begin
            if ((r_rs1 != '0) && (wb_rd == r_rs1)) r_src1 <= wb_data;
            if (r_src2_reg && (r_rs2 != '0) && (wb_rd == r_rs2)) r_src2 <= wb_data;
        end
    end

    assign out_src1      = r_src1;
    assign out_src2      = r_src2;
    assign out_funct3    = r_funct3;
    assign out_is_branch = r_is_branch;
    assign out_rd        = r_rd;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_stat_issued, r_stat_stall, r_stat_fwd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
            r_stat_fwd    <= '0;
        end else begin
            if (w_fire)                  r_stat_issued <= r_stat_issued + 32'd1;
            if (out_valid && !out_ready) r_stat_stall  <= r_stat_stall + 32'd1;
            if (w_load_out)
                r_stat_fwd <= r_stat_fwd + 32'(w_ld_fwd1) + 32'(w_ld_fwd2 && !w_ld_op.use_imm);
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_stall   = r_stat_stall;
    assign stat_fwd     = r_stat_fwd;
    assign w_unused_fwd = w_sk_fwd1 ^ w_sk_fwd2;
`else
    assign w_unused_fwd = w_sk_fwd1 ^ w_sk_fwd2 ^ w_ld_fwd1 ^ w_ld_fwd2;
`endif
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus a random program checked against program-order register semantics.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  in_funct3 = '0;
    logic        in_is_branch = 1'b0, in_use_imm = 1'b0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, alu_result = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_src1, out_src2;
    logic [2:0]  out_funct3;
    logic        out_is_branch;
    logic [4:0]  out_rd;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_issued, stat_stall, stat_fwd;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_is_branch(in_is_branch), .in_use_imm(in_use_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_rd(in_rd), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
        .out_funct3(out_funct3), .out_is_branch(out_is_branch), .out_rd(out_rd)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall), .stat_fwd(stat_fwd)
`endif
    );

    typedef struct {
        logic [2:0]  f3;
        logic        br, ui;
        logic [4:0]  rs1, rs2, rd, erd;
        logic [31:0] imm, res, e1, e2;
    } tb_op_t;

    task automatic put(input logic [2:0] f3, input logic br, input logic ui, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [4:0] rd);
        in_valid = 1'b1; in_funct3 = f3; in_is_branch = br; in_use_imm = ui;
        in_rs1 = rs1; in_rs2 = rs2; in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_rd = rd;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_chk++; if ({out_src1, out_src2, out_funct3, out_is_branch, out_rd} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got=%h/%h/%h/%b/%h exp=0", out_src1, out_src2, out_funct3, out_is_branch, out_rd); end
        rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk); out_ready = 1'b0;
        put(3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 5'd5);
        @(negedge clk);
        n_chk++; if (out_src1 !== 32'd3 || out_src2 !== 32'd4 || out_rd !== 5'd5) begin
            n_fail++; $display("FAIL b2b_opA got=%h/%h rd=%0d exp=3/4 rd=5", out_src1, out_src2, out_rd); end
        put(3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 32'hDEAD, 32'h55, 32'd0, 5'd6);
        out_ready = 1'b1; alu_result = 32'h0000_0007;
        @(negedge clk); idle_in();
        n_chk++; if (out_src1 !== 32'd7) begin n_fail++; $display("FAIL b2b_ex_src1 got=%h exp=7", out_src1); end
        n_chk++; if (out_src2 !== 32'd0) begin n_fail++; $display("FAIL b2b_x0_src2 got=%h exp=0", out_src2); end
        @(negedge clk); out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_wb_forward();
        @(negedge clk); out_ready = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
        put(3'b100, 1'b0, 1'b0, 5'd0, 5'd3, 32'h9, 32'd0, 32'd0, 5'd1);
        @(negedge clk);
        n_chk++; if (out_src2 !== 32'h1234 || out_src1 !== 32'd0) begin
            n_fail++; $display("FAIL wb_src2 got=%h/%h exp=0/1234", out_src1, out_src2); end
        put(3'b000, 1'b0, 1'b1, 5'd0, 5'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 5'd2);
        out_ready = 1'b1;
        @(negedge clk); idle_in(); wb_valid = 1'b0;
        n_chk++; if (out_src2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wb_imm_src2 got=%h exp=ffffffff", out_src2); end
        @(negedge clk); out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wb_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk); out_ready = 1'b0; alu_result = 32'h0;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rdy0 got=%b exp=1", in_ready); end
        put(3'd0, 1'b0, 1'b0, 5'd20, 5'd0, 32'h100, 32'h0, 32'h0, 5'd10);
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rdy1 got=%b exp=1", in_ready); end
        put(3'd1, 1'b0, 1'b0, 5'd21, 5'd0, 32'h101, 32'h0, 32'h0, 5'd11);
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rdy2 got=%b exp=0", in_ready); end
        put(3'd2, 1'b0, 1'b0, 5'd22, 5'd0, 32'h102, 32'h0, 32'h0, 5'd12);
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rdy3 got=%b exp=0", in_ready); end
        n_chk++; if (out_src1 !== 32'h100 || out_rd !== 5'd10) begin
            n_fail++; $display("FAIL bp_first got=%h rd=%0d exp=100 rd=10", out_src1, out_rd); end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || out_src1 !== 32'h101 || out_funct3 !== 3'd1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second got=v%b %h f3=%0d rdy=%b exp=v1 101 f3=1 rdy=1", out_valid, out_src1, out_funct3, in_ready); end
        @(negedge clk); idle_in();
        n_chk++; if (out_valid !== 1'b1 || out_src1 !== 32'h102 || out_rd !== 5'd12) begin
            n_fail++; $display("FAIL bp_third got=v%b %h rd=%0d exp=v1 102 rd=12", out_valid, out_src1, out_rd); end
        @(negedge clk); out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_held_refresh();
        @(negedge clk); out_ready = 1'b0;
        put(3'd0, 1'b0, 1'b0, 5'd7, 5'd0, 32'd0, 32'd0, 32'd0, 5'd8);
        @(negedge clk); idle_in();
        n_chk++; if (out_src1 !== 32'd0) begin n_fail++; $display("FAIL held_before got=%h exp=0", out_src1); end
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
        @(negedge clk); wb_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || out_src1 !== 32'hAA) begin
            n_fail++; $display("FAIL held_refresh got=v%b %h exp=v1 aa", out_valid, out_src1); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL held_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_branch_x0();
        @(negedge clk); out_ready = 1'b0;
        put(3'b001, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd4);
        @(negedge clk);
        n_chk++; if (out_rd !== 5'd0 || out_is_branch !== 1'b1 || out_funct3 !== 3'b001) begin
            n_fail++; $display("FAIL br_fields got=rd%0d br%b f3=%0d exp=rd0 br1 f3=1", out_rd, out_is_branch, out_funct3); end
        put(3'd0, 1'b0, 1'b0, 5'd4, 5'd0, 32'h44, 32'd0, 32'd0, 5'd9);
        out_ready = 1'b1; alu_result = 32'h999;
        @(negedge clk);
        n_chk++; if (out_src1 !== 32'h44) begin n_fail++; $display("FAIL br_no_fwd got=%h exp=44", out_src1); end
        put(3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h77, 32'd0, 32'd0, 5'd9);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'd9;
        @(negedge clk); idle_in(); wb_valid = 1'b0;
        n_chk++; if (out_src1 !== 32'd0) begin n_fail++; $display("FAIL x0_src1 got=%h exp=0", out_src1); end
        @(negedge clk); out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL br_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); out_ready = 1'b0;
        put(3'd3, 1'b0, 1'b0, 5'd1, 5'd2, 32'h11, 32'h22, 32'd0, 5'd3);
        @(negedge clk);
        put(3'd4, 1'b0, 1'b0, 5'd1, 5'd2, 32'h33, 32'h44, 32'd0, 5'd5);
        @(negedge clk); idle_in();
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got=%b exp=0", in_ready); end
        rstn = 1'b0;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ctrl got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        n_chk++; if ({out_src1, out_src2, out_funct3, out_is_branch, out_rd} !== '0) begin
            n_fail++; $display("FAIL rstmid_data got=%h/%h/%h/%b/%h exp=0", out_src1, out_src2, out_funct3, out_is_branch, out_rd); end
`ifdef ALU_ISSUE_STATS_EN
        n_chk++; if ({stat_issued, stat_stall, stat_fwd} !== '0) begin
            n_fail++; $display("FAIL rstmid_stats got=%0d/%0d/%0d exp=0", stat_issued, stat_stall, stat_fwd); end
`endif
        rstn = 1'b1;
    endtask

    // Random program; expected operands are the last older writer's result in program order
    task automatic test_random();
        logic [31:0] rf [32];
        logic [31:0] arch [32];
        tb_op_t q[$];
        tb_op_t pend;
        bit have_pend = 0, prev_offer = 0, prev_ready = 0;
        bit wb_pend = 0, wb_now = 0;
        logic [4:0]  wbp_rd = '0, wbn_rd = '0;
        logic [31:0] wbp_d = '0, wbn_d = '0;
        int n_gen = 0, n_fired = 0;
        for (int i = 0; i < 32; i++) begin rf[i] = $urandom; arch[i] = (i == 0) ? 32'd0 : rf[i]; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (wb_now && wbn_rd != 5'd0) rf[wbn_rd] = wbn_d;
            if (prev_offer && prev_ready) begin q.push_back(pend); have_pend = 0; end
            n_chk++; if (out_valid !== (q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() > 0); end
            n_chk++; if (in_ready !== (q.size() < 2)) begin
                n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2); end
            wb_now = wb_pend; wbn_rd = wbp_rd; wbn_d = wbp_d; wb_pend = 0;
            if (wb_now) begin wb_valid = 1'b1; wb_rd = wbn_rd; wb_data = wbn_d; end
            else if ($urandom_range(0, 7) == 0) begin wb_valid = 1'b1; wb_rd = 5'd0; wb_data = $urandom; end
            else wb_valid = 1'b0;
            if (!have_pend && cyc < 2800) begin
                pend.f3 = 3'($urandom_range(0, 7)); pend.br = ($urandom_range(0, 4) == 0);
                pend.ui = ($urandom_range(0, 2) == 0);
                pend.rs1 = 5'($urandom_range(0, 7)); pend.rs2 = 5'($urandom_range(0, 7));
                pend.rd = 5'($urandom_range(0, 7)); pend.imm = $urandom; pend.res = $urandom;
                pend.e1 = arch[pend.rs1];
                pend.e2 = pend.ui ? pend.imm : arch[pend.rs2];
                pend.erd = pend.br ? 5'd0 : pend.rd;
                if (pend.erd != 5'd0) arch[pend.erd] = pend.res;
                have_pend = 1; n_gen++;
            end
            prev_offer = have_pend && ($urandom_range(0, 3) != 0);
            if (prev_offer) put(pend.f3, pend.br, pend.ui, pend.rs1, pend.rs2, rf[pend.rs1], rf[pend.rs2], pend.imm, pend.rd);
            else idle_in();
            prev_ready = in_ready;
            out_ready = (cyc >= 2800) || ($urandom_range(0, 2) != 0);
            alu_result = (out_ready && q.size() > 0) ? q[0].res : $urandom;
            if (out_valid && out_ready && q.size() > 0) begin
                n_chk++; if (out_src1 !== q[0].e1 || out_src2 !== q[0].e2) begin
                    n_fail++; $display("FAIL rnd_operands op=%0d got=%h/%h exp=%h/%h", n_fired, out_src1, out_src2, q[0].e1, q[0].e2); end
                n_chk++; if (out_funct3 !== q[0].f3 || out_is_branch !== q[0].br || out_rd !== q[0].erd) begin
                    n_fail++; $display("FAIL rnd_ctrl op=%0d got=f%0d b%b rd%0d exp=f%0d b%b rd%0d", n_fired, out_funct3, out_is_branch, out_rd, q[0].f3, q[0].br, q[0].erd); end
                if (q[0].erd != 5'd0) begin wb_pend = 1; wbp_rd = q[0].erd; wbp_d = q[0].res; end
                void'(q.pop_front()); n_fired++;
            end
        end
        @(negedge clk); idle_in(); wb_valid = 1'b0; out_ready = 1'b0;
        n_chk++; if (have_pend || q.size() != 0 || n_fired != n_gen) begin
            n_fail++; $display("FAIL rnd_drain got fired=%0d queued=%0d pend=%0d exp fired=%0d queued=0 pend=0", n_fired, q.size(), have_pend, n_gen); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wb_forward();
        test_backpressure();
        test_held_refresh();
        test_branch_x0();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
